// File: rtl/counter_load_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : counter_load_ctrl_if
// Description : Button, switch and counter-control signals between the
//               load controller and its surroundings.
// Revision    : 1.0 - initial release
// ============================================================================
interface counter_load_ctrl_if #(
  parameter int DATA_W = 10
);
  logic              key_i;        // raw load button, active-low, asynchronous
  logic              clr_key_i;    // raw clear button, active-low, asynchronous
  logic [DATA_W-1:0] sw_i;         // switch word, quasi-static
  logic              load_en_o;    // one-cycle load strobe
  logic [DATA_W-1:0] load_data_o;  // captured switch word
  logic              clear_o;      // one-cycle clear strobe
  logic [7:0]        load_cnt_o;   // accepted loads since reset/clear
  logic              full_o;       // load count has reached its cap
  logic              busy_o;       // controller not idle

  // Board/testbench side: drives buttons and switches, observes strobes
  modport master (
    output key_i, clr_key_i, sw_i,
    input  load_en_o, load_data_o, clear_o, load_cnt_o, full_o, busy_o
  );

  // Controller side
  modport slave (
    input  key_i, clr_key_i, sw_i,
    output load_en_o, load_data_o, clear_o, load_cnt_o, full_o, busy_o
  );
endinterface
`default_nettype wire

// File: rtl/counter_load_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : counter_load_ctrl
// Description : Synchronizes and debounces the active-low load button,
//               issues one load strobe (with captured switch word) per
//               press, caps accepted loads and issues a clear strobe from
//               a second button.
// Revision    : 1.0 - initial release
// ============================================================================
module counter_load_ctrl #(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int DATA_W          = 10,
  parameter int MAX_LOADS       = 255
) (
  input  wire logic           clk100_i,
  input  wire logic           rst_i,
  counter_load_ctrl_if.slave  bus
);

  // Last debounce count value before a press/release is accepted
  localparam logic [19:0] c_deb_last  = 20'(DEBOUNCE_CYCLES - 1);
  localparam logic [7:0]  c_max_loads = 8'(MAX_LOADS);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_PRESS   = 2'd1,
    S_FIRE    = 2'd2,
    S_RELEASE = 2'd3
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic [19:0] r_deb_cnt;
  logic [19:0] w_deb_cnt_nxt;

  // Two-stage synchronizers; the extra clear stage remembers the previous
  // synchronized level for falling-edge detection.
  logic r_key_s1;
  logic r_key_s2;
  logic r_clr_s1;
  logic r_clr_s2;
  logic r_clr_prev;

  logic w_clr_fall;   // synchronized clear button just pressed
  logic w_fire_go;    // debounced press accepted on this edge
  logic w_deb_done;   // debounce counter at its terminal value

  logic [7:0]        w_cnt_inc;
  logic              r_load_en;
  logic [DATA_W-1:0] r_load_data;
  logic              r_clear;
  logic [7:0]        r_load_cnt;
  logic              r_full;

  // Bring both raw buttons into the clock domain; idle level is released (1)
  always_ff @(posedge clk100_i or posedge rst_i) begin
    if (rst_i) begin
      r_key_s1   <= 1'b1;
      r_key_s2   <= 1'b1;
      r_clr_s1   <= 1'b1;
      r_clr_s2   <= 1'b1;
      r_clr_prev <= 1'b1;
    end else begin
      r_key_s1   <= bus.key_i;
      r_key_s2   <= r_key_s1;
      r_clr_s1   <= bus.clr_key_i;
      r_clr_s2   <= r_clr_s1;
      r_clr_prev <= r_clr_s2;
    end
  end

  assign w_clr_fall = r_clr_prev & ~r_clr_s2;
  assign w_deb_done = (r_deb_cnt == c_deb_last);

  // FSM state and debounce counter registers
  always_ff @(posedge clk100_i or posedge rst_i) begin
    if (rst_i) begin
      r_state   <= S_IDLE;
      r_deb_cnt <= 20'd0;
    end else begin
      r_state   <= w_state_nxt;
      r_deb_cnt <= w_deb_cnt_nxt;
    end
  end

  // Next-state logic; a clear overrides whatever the debouncer was doing,
  // including an accept on the same edge, and parks the FSM in RELEASE if
  // the load key is still held so that press cannot produce a load later.
  always_comb begin
    w_state_nxt   = r_state;
    w_deb_cnt_nxt = r_deb_cnt;
    w_fire_go     = 1'b0;
    if (w_clr_fall) begin
      w_state_nxt   = r_key_s2 ? S_IDLE : S_RELEASE;
      w_deb_cnt_nxt = 20'd0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (!r_key_s2) begin
            w_state_nxt   = S_PRESS;
            w_deb_cnt_nxt = 20'd0;
          end
        end
        S_PRESS: begin
          if (r_key_s2) begin
            w_state_nxt   = S_IDLE;
            w_deb_cnt_nxt = 20'd0;
          end else if (w_deb_done) begin
            w_state_nxt   = S_FIRE;
            w_deb_cnt_nxt = 20'd0;
            w_fire_go     = 1'b1;
          end else begin
            w_deb_cnt_nxt = r_deb_cnt + 20'd1;
          end
        end
        S_FIRE: begin
          w_state_nxt   = S_RELEASE;
          w_deb_cnt_nxt = 20'd0;
        end
        S_RELEASE: begin
          if (!r_key_s2) begin
            w_deb_cnt_nxt = 20'd0;
          end else if (w_deb_done) begin
            w_state_nxt   = S_IDLE;
            w_deb_cnt_nxt = 20'd0;
          end else begin
            w_deb_cnt_nxt = r_deb_cnt + 20'd1;
          end
        end
        default: begin
          w_state_nxt   = S_IDLE;
          w_deb_cnt_nxt = 20'd0;
        end
      endcase
    end
  end

  assign w_cnt_inc = r_load_cnt + 8'd1;

  // Strobes, captured data and load accounting, all updated on the edge
  // that enters FIRE so the strobe appears during the FIRE cycle.
  always_ff @(posedge clk100_i or posedge rst_i) begin
    if (rst_i) begin
      r_load_en   <= 1'b0;
      r_load_data <= '0;
      r_clear     <= 1'b0;
      r_load_cnt  <= 8'd0;
      r_full      <= 1'b0;
    end else begin
      r_load_en <= 1'b0;
      r_clear   <= 1'b0;
      if (w_clr_fall) begin
        r_clear    <= 1'b1;
        r_load_cnt <= 8'd0;
        r_full     <= 1'b0;
      end else if (w_fire_go && !r_full) begin
        r_load_en   <= 1'b1;
        r_load_data <= bus.sw_i;
        r_load_cnt  <= w_cnt_inc;
        r_full      <= (w_cnt_inc == c_max_loads);
      end
    end
  end

  assign bus.load_en_o   = r_load_en;
  assign bus.load_data_o = r_load_data;
  assign bus.clear_o     = r_clear;
  assign bus.load_cnt_o  = r_load_cnt;
  assign bus.full_o      = r_full;
  assign bus.busy_o      = (r_state != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_counter_load_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_counter_load_ctrl
// Description : Directed self-checking bench for counter_load_ctrl
//               (DEBOUNCE_CYCLES=4, MAX_LOADS=3).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_counter_load_ctrl;

  localparam int c_deb  = 4;
  localparam int c_dw   = 10;
  localparam int c_max  = 3;

  logic clk;
  logic rst;

  int errors = 0;
  int checks = 0;

  // Strobe bookkeeping from the monitor
  int          n_load  = 0;
  int          n_clear = 0;
  int          n_wide  = 0;
  logic [9:0]  last_data = '0;
  logic        prev_load = 1'b0;
  logic        prev_clear = 1'b0;

  int          base;

  counter_load_ctrl_if #(.DATA_W(c_dw)) bus ();

  counter_load_ctrl #(
    .DEBOUNCE_CYCLES(c_deb),
    .DATA_W         (c_dw),
    .MAX_LOADS      (c_max)
  ) dut (
    .clk100_i(clk),
    .rst_i   (rst),
    .bus     (bus)
  );

  // 100 MHz clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Count strobes mid-cycle and flag any strobe longer than one cycle
  always @(negedge clk) begin
    if (bus.load_en_o) begin
      n_load    = n_load + 1;
      last_data = bus.load_data_o;
    end
    if (bus.clear_o) n_clear = n_clear + 1;
    if (bus.load_en_o && prev_load) n_wide = n_wide + 1;
    if (bus.clear_o && prev_clear) n_wide = n_wide + 1;
    prev_load  = bus.load_en_o;
    prev_clear = bus.clear_o;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks = checks + 1;
    if (got !== exp) begin
      errors = errors + 1;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    repeat (n) tick();
  endtask

  // Clean press held for 'hold' cycles, then released until idle again
  task automatic press_release(input logic [9:0] sw, input int hold);
    bus.sw_i  = sw;
    bus.key_i = 1'b0;
    ticks(hold);
    bus.key_i = 1'b1;
    ticks(12);
  endtask

  // Clear button press and release
  task automatic clear_press();
    bus.clr_key_i = 1'b0;
    ticks(2);
    check("clr_before", bus.clear_o, 1'b0);
    tick();
    check("clr_pulse", bus.clear_o, 1'b1);
    check("clr_cnt", bus.load_cnt_o, 8'd0);
    check("clr_full", bus.full_o, 1'b0);
    tick();
    check("clr_after", bus.clear_o, 1'b0);
    ticks(4);
    bus.clr_key_i = 1'b1;
    ticks(4);
  endtask

  initial begin
    rst           = 1'b1;
    bus.key_i     = 1'b1;
    bus.clr_key_i = 1'b1;
    bus.sw_i      = '0;
    ticks(3);

    // Reset state
    check("rst_load_en", bus.load_en_o, 1'b0);
    check("rst_data", bus.load_data_o, 10'h000);
    check("rst_clear", bus.clear_o, 1'b0);
    check("rst_cnt", bus.load_cnt_o, 8'd0);
    check("rst_full", bus.full_o, 1'b0);
    check("rst_busy", bus.busy_o, 1'b0);
    rst = 1'b0;
    ticks(3);

    // Clean press: strobe in the cycle after edge DEBOUNCE_CYCLES+3 = 7
    base      = n_load;
    bus.sw_i  = 10'h155;
    bus.key_i = 1'b0;
    ticks(6);
    check("press_e6", bus.load_en_o, 1'b0);
    tick();
    check("press_e7", bus.load_en_o, 1'b1);
    check("press_data", bus.load_data_o, 10'h155);
    check("press_cnt", bus.load_cnt_o, 8'd1);
    tick();
    check("press_e8", bus.load_en_o, 1'b0);
    ticks(12);
    check("press_held_once", n_load - base, 1);
    bus.key_i = 1'b1;
    ticks(5);
    check("rel_busy_e5", bus.busy_o, 1'b1);
    tick();
    check("rel_busy_e6", bus.busy_o, 1'b0);
    ticks(4);

    // Bounce rejection: low 2 / high 1, five times
    base     = n_load;
    bus.sw_i = 10'h0AA;
    for (int i = 0; i < 5; i++) begin
      bus.key_i = 1'b0;
      ticks(2);
      bus.key_i = 1'b1;
      tick();
    end
    ticks(10);
    check("bounce_no_load", n_load - base, 0);
    check("bounce_cnt", bus.load_cnt_o, 8'd1);
    press_release(10'h0AA, 10);
    check("bounce_then_one", n_load - base, 1);
    check("bounce_data", last_data, 10'h0AA);
    check("bounce_cnt2", bus.load_cnt_o, 8'd2);

    // Clear back to zero before the cap test
    base = n_clear;
    clear_press();
    check("clear1_once", n_clear - base, 1);

    // Cap at three loads
    base = n_load;
    for (int i = 1; i <= 5; i++) begin
      press_release(10'(i), 10);
      check("cap_data", bus.load_data_o, (i <= 3) ? i : 3);
    end
    check("cap_strobes", n_load - base, 3);
    check("cap_full", bus.full_o, 1'b1);
    check("cap_cnt", bus.load_cnt_o, 8'd3);
    check("cap_data_hold", bus.load_data_o, 10'h003);

    // Clear, then a fresh press with all switches up
    base = n_clear;
    clear_press();
    check("clear2_once", n_clear - base, 1);
    base = n_load;
    press_release(10'h3FF, 10);
    check("after_clr_strobe", n_load - base, 1);
    check("after_clr_data", last_data, 10'h3FF);
    check("after_clr_cnt", bus.load_cnt_o, 8'd1);

    // Collision: clear detection lands on the edge that would enter FIRE
    base      = n_load;
    bus.sw_i  = 10'h123;
    bus.key_i = 1'b0;
    ticks(4);
    bus.clr_key_i = 1'b0;
    ticks(3);
    check("coll_clear", bus.clear_o, 1'b1);
    check("coll_load_en", bus.load_en_o, 1'b0);
    check("coll_cnt", bus.load_cnt_o, 8'd0);
    ticks(6);
    bus.key_i     = 1'b1;
    bus.clr_key_i = 1'b1;
    ticks(12);
    check("coll_no_load", n_load - base, 0);
    check("coll_cnt_end", bus.load_cnt_o, 8'd0);
    check("coll_idle", bus.busy_o, 1'b0);

    // Reset mid-press
    base      = n_load;
    bus.sw_i  = 10'h2C3;
    bus.key_i = 1'b0;
    ticks(5);
    check("midrst_busy", bus.busy_o, 1'b1);
    rst = 1'b1;
    #1;
    check("midrst_busy0", bus.busy_o, 1'b0);
    check("midrst_data0", bus.load_data_o, 10'h000);
    check("midrst_cnt0", bus.load_cnt_o, 8'd0);
    ticks(2);
    rst = 1'b0;
    ticks(6);
    check("midrst_e6", bus.load_en_o, 1'b0);
    tick();
    check("midrst_e7", bus.load_en_o, 1'b1);
    check("midrst_data", bus.load_data_o, 10'h2C3);
    bus.key_i = 1'b1;
    ticks(12);
    check("midrst_once", n_load - base, 1);
    check("midrst_cnt", bus.load_cnt_o, 8'd1);

    // Totals over the whole run
    check("total_loads", n_load, 7);
    check("total_clears", n_clear, 3);
    check("strobe_width", n_wide, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
